// File: rtl/issue_pkg.sv
// Shared types for the issue queue.
//   uop_t : micro-op as held in the queue. The fields are src1/v1/p1,
//           src2/v2/p2, pdst and ctrl.
//           vN = operand N is used; pN = operand N has been produced.
//   PREG_BITS_DEFAULT / CTRL_BITS_DEFAULT : widths baked into uop_t.
package issue_pkg;

  localparam int PREG_BITS_DEFAULT = 7;
  localparam int CTRL_BITS_DEFAULT = 8;

  typedef struct packed {
    logic [PREG_BITS_DEFAULT-1:0] src1;
    logic                         v1;
    logic                         p1;
    logic [PREG_BITS_DEFAULT-1:0] src2;
    logic                         v2;
    logic                         p2;
    logic [PREG_BITS_DEFAULT-1:0] pdst;
    logic [CTRL_BITS_DEFAULT-1:0] ctrl;
  } uop_t;

  // An operand is satisfied when it is unused or already produced.
  function automatic logic operands_ready(input uop_t u);
    return (!u.v1 || u.p1) && (!u.v2 || u.p2);
  endfunction

endpackage

// File: rtl/iq_wakeup_entry.sv
// One issue-queue slot: valid bit, uop register and wakeup CAM.
// The slot reloads every cycle from the compaction mux (in_valid/in_uop).
// The wakeup match is applied to whatever is being loaded. A tag that is
// broadcast on the same edge therefore lands whether the uop is shifting
// down or arriving from dispatch.
//   clk, reset             : clock, async active-low reset (valid only)
//   in_valid, in_uop       : next contents chosen by the top level
//   wakeup_valid/_pdst     : writeback tag broadcasts
//   ent_valid, ent_uop     : registered slot contents
//   ent_ready              : valid with all used operands produced
module iq_wakeup_entry
  import issue_pkg::*;
#(
  parameter int NUM_WAKEUP_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  uop_t                         in_uop,
  input  logic [NUM_WAKEUP_PORTS-1:0]  wakeup_valid,
  input  logic [PREG_BITS_DEFAULT-1:0] wakeup_pdst [NUM_WAKEUP_PORTS],
  output logic                         ent_valid,
  output uop_t                         ent_uop,
  output logic                         ent_ready
);

  uop_t woken;

  always_comb begin
    woken = in_uop;
    for (int w = 0; w < NUM_WAKEUP_PORTS; w++) begin
      if (wakeup_valid[w]) begin
        if (wakeup_pdst[w] == in_uop.src1) woken.p1 = 1'b1;
        if (wakeup_pdst[w] == in_uop.src2) woken.p2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ent_valid <= 1'b0;
    else        ent_valid <= in_valid;
  end

  // Payload is meaningless while ent_valid=0, so it carries no reset.
  always_ff @(posedge clk) begin
    ent_uop <= woken;
  end

  assign ent_ready = ent_valid && operands_ready(ent_uop);

endmodule

// File: rtl/collapsing_issue_queue.sv
// Age-ordered collapsing issue queue. Slot 0 always holds the oldest uop,
// and the valid slots are contiguous from slot 0.
//   clk, reset              : clock, async active-low reset
//   dis_valid, dis_uop      : dispatch lanes, accepted all-or-nothing
//   dis_ready               : registered; room for DISPATCH_WIDTH uops
//   wakeup_valid/_pdst      : writeback tag broadcasts
//   iss_ready               : per execution port, can take a uop
//   iss_valid, iss_uop      : issued uops (combinational on iss_ready)
//   flush                   : synchronous kill of all entries
//   count                   : registered occupancy
module collapsing_issue_queue
  import issue_pkg::*;
#(
  parameter int DISPATCH_WIDTH   = 2,
  parameter int ISSUE_WIDTH      = 2,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int NUM_ISSUE_SLOTS  = 8,
  parameter int PREG_BITS        = PREG_BITS_DEFAULT,
  parameter int CTRL_BITS        = CTRL_BITS_DEFAULT,
  localparam int CNT_W           = $clog2(NUM_ISSUE_SLOTS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DISPATCH_WIDTH-1:0]   dis_valid,
  input  uop_t                        dis_uop [DISPATCH_WIDTH],
  output logic                        dis_ready,
  input  logic [NUM_WAKEUP_PORTS-1:0] wakeup_valid,
  input  logic [PREG_BITS-1:0]        wakeup_pdst [NUM_WAKEUP_PORTS],
  input  logic [ISSUE_WIDTH-1:0]      iss_ready,
  output logic [ISSUE_WIDTH-1:0]      iss_valid,
  output uop_t                        iss_uop [ISSUE_WIDTH],
  input  logic                        flush,
  output logic [CNT_W-1:0]            count
);

  // uop_t is a package type, so the field widths cannot follow these
  // parameters; refuse to elaborate rather than silently truncate.
  if (PREG_BITS != PREG_BITS_DEFAULT || CTRL_BITS != CTRL_BITS_DEFAULT) begin : g_width_check
    $error("PREG_BITS/CTRL_BITS must match issue_pkg uop_t widths");
  end

  logic [NUM_ISSUE_SLOTS-1:0] ent_valid;
  logic [NUM_ISSUE_SLOTS-1:0] ent_ready;
  logic [NUM_ISSUE_SLOTS-1:0] issued;
  logic [NUM_ISSUE_SLOTS-1:0] nxt_valid;
  uop_t                       ent_uop [NUM_ISSUE_SLOTS];
  uop_t                       nxt_uop [NUM_ISSUE_SLOTS];
  logic [DISPATCH_WIDTH-1:0]  accepted;
  logic [CNT_W-1:0]           count_next;
  logic                       dis_ready_next;

  for (genvar i = 0; i < NUM_ISSUE_SLOTS; i++) begin : g_entry
    iq_wakeup_entry #(
      .NUM_WAKEUP_PORTS(NUM_WAKEUP_PORTS)
    ) u_entry (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (nxt_valid[i]),
      .in_uop      (nxt_uop[i]),
      .wakeup_valid(wakeup_valid),
      .wakeup_pdst (wakeup_pdst),
      .ent_valid   (ent_valid[i]),
      .ent_uop     (ent_uop[i]),
      .ent_ready   (ent_ready[i])
    );
  end

  // Select: the k-th ready port (by port number) takes the k-th oldest
  // ready entry. Only registered entry state feeds this, so a wakeup
  // never bypasses into select in the cycle it is broadcast.
  always_comb begin
    int port_rank;
    int rdy_rank;
    iss_valid = '0;
    issued    = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) iss_uop[k] = '0;
    port_rank = 0;
    rdy_rank  = 0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (iss_ready[k] && !flush) begin
        rdy_rank = 0;
        for (int i = 0; i < NUM_ISSUE_SLOTS; i++) begin
          if (ent_ready[i]) begin
            if (rdy_rank == port_rank) begin
              iss_valid[k] = 1'b1;
              iss_uop[k]   = ent_uop[i];
              issued[i]    = 1'b1;
            end
            rdy_rank++;
          end
        end
        port_rank++;
      end
    end
  end

  assign accepted = dis_valid & {DISPATCH_WIDTH{dis_ready && !flush}};

  // Compaction: survivors slide down in age order, then the accepted lanes
  // are packed behind them in lane order. The running write position ends
  // at the new occupancy. Under flush nothing survives or is accepted.
  always_comb begin
    int pos;
    for (int j = 0; j < NUM_ISSUE_SLOTS; j++) begin
      nxt_valid[j] = 1'b0;
      nxt_uop[j]   = '0;
    end
    pos = 0;
    for (int i = 0; i < NUM_ISSUE_SLOTS; i++) begin
      if (ent_valid[i] && !issued[i] && !flush) begin
        for (int j = 0; j < NUM_ISSUE_SLOTS; j++) begin
          if (pos == j) begin
            nxt_valid[j] = 1'b1;
            nxt_uop[j]   = ent_uop[i];
          end
        end
        pos++;
      end
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (accepted[l]) begin
        for (int j = 0; j < NUM_ISSUE_SLOTS; j++) begin
          if (pos == j) begin
            nxt_valid[j] = 1'b1;
            nxt_uop[j]   = dis_uop[l];
          end
        end
        pos++;
      end
    end
    count_next     = CNT_W'(pos);
    // Conservative: next cycle's issues are not credited.
    dis_ready_next = (NUM_ISSUE_SLOTS - pos) >= DISPATCH_WIDTH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      dis_ready <= 1'b1;
    end else begin
      count     <= count_next;
      dis_ready <= dis_ready_next;
    end
  end

endmodule

// File: tb/tb_collapsing_issue_queue.sv
module tb_collapsing_issue_queue;
  import issue_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dis_valid;
  uop_t       dis_uop [2];
  logic       dis_ready;
  logic [1:0] wakeup_valid;
  logic [6:0] wakeup_pdst [2];
  logic [1:0] iss_ready;
  logic [1:0] iss_valid;
  uop_t       iss_uop [2];
  logic       flush;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  collapsing_issue_queue #(
    .DISPATCH_WIDTH(2), .ISSUE_WIDTH(2), .NUM_WAKEUP_PORTS(2),
    .NUM_ISSUE_SLOTS(8), .PREG_BITS(7), .CTRL_BITS(8)
  ) dut (
    .clk(clk), .reset(reset),
    .dis_valid(dis_valid), .dis_uop(dis_uop), .dis_ready(dis_ready),
    .wakeup_valid(wakeup_valid), .wakeup_pdst(wakeup_pdst),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_uop(iss_uop),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  typedef struct {
    logic [1:0] dv;
    uop_t       u0;
    uop_t       u1;
    logic [1:0] wv;
    logic [6:0] wp0;
    logic [6:0] wp1;
    logic [1:0] ir;
    logic       fl;
    logic [1:0] e_iv;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
    logic [3:0] e_cnt;
    logic       e_dr;
  } vec_t;

  vec_t vecs[$];

  function automatic uop_t rdy(input logic [7:0] c);
    uop_t u;
    u = '0;
    u.ctrl = c;
    u.pdst = c[6:0];
    return u;
  endfunction

  function automatic uop_t wt1(input logic [6:0] s, input logic [7:0] c);
    uop_t u;
    u = rdy(c);
    u.src1 = s;
    u.v1 = 1'b1;
    return u;
  endfunction

  function automatic uop_t wt2(input logic [6:0] s, input logic [7:0] c);
    uop_t u;
    u = rdy(c);
    u.src2 = s;
    u.v2 = 1'b1;
    return u;
  endfunction

  function automatic void add(input logic [1:0] dv, input uop_t u0, input uop_t u1,
                              input logic [1:0] wv, input logic [6:0] wp0, input logic [6:0] wp1,
                              input logic [1:0] ir, input logic fl, input logic [1:0] e_iv,
                              input logic [7:0] e_c0, input logic [7:0] e_c1,
                              input logic [3:0] e_cnt, input logic e_dr);
    vec_t v;
    v.dv = dv; v.u0 = u0; v.u1 = u1; v.wv = wv; v.wp0 = wp0; v.wp1 = wp1;
    v.ir = ir; v.fl = fl; v.e_iv = e_iv; v.e_c0 = e_c0; v.e_c1 = e_c1;
    v.e_cnt = e_cnt; v.e_dr = e_dr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    dis_valid = '0;
    dis_uop[0] = '0;
    dis_uop[1] = '0;
    wakeup_valid = '0;
    wakeup_pdst[0] = '0;
    wakeup_pdst[1] = '0;
    iss_ready = '0;
    flush = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    dis_valid = v.dv;
    dis_uop[0] = v.u0;
    dis_uop[1] = v.u1;
    wakeup_valid = v.wv;
    wakeup_pdst[0] = v.wp0;
    wakeup_pdst[1] = v.wp1;
    iss_ready = v.ir;
    flush = v.fl;
  endtask

  initial begin
    uop_t z;
    z = '0;
    // Fields: dv, u0, u1, wv, wp0, wp1, ir, fl | e_iv, e_c0, e_c1, e_cnt, e_dr
    // Two unconditionally ready uops: write, issue on both ports, drain.
    add(2'b11, rdy(8'h01), rdy(8'h02), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h01, 8'h02, 2, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    // Fill all 8 slots waiting on tag 5, wake them on bus 1, drain in order.
    add(2'b11, wt1(5, 8'h10), wt1(5, 8'h11), 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b11, wt1(5, 8'h12), wt1(5, 8'h13), 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 2, 1);
    add(2'b11, wt1(5, 8'h14), wt1(5, 8'h15), 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 4, 1);
    add(2'b11, wt1(5, 8'h16), wt1(5, 8'h17), 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 6, 1);
    add(2'b00, z, z, 2'b10, 0, 5, 2'b11, 0, 2'b00, 8'h00, 8'h00, 8, 0);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h10, 8'h11, 8, 0);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h12, 8'h13, 6, 1);
    // Only port 1 ready: it takes the oldest; then port 0 alone; then both.
    add(2'b00, z, z, 2'b00, 0, 0, 2'b10, 0, 2'b10, 8'h00, 8'h14, 4, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b01, 0, 2'b01, 8'h15, 8'h00, 3, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h16, 8'h17, 2, 1);
    // Occupancy 7 -> dis_ready low; a dropped dispatch must not appear later.
    add(2'b11, rdy(8'h20), wt1(6, 8'h21), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b11, wt1(6, 8'h22), wt1(6, 8'h23), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 2, 1);
    add(2'b11, wt1(6, 8'h24), wt1(6, 8'h25), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 4, 1);
    add(2'b01, wt1(6, 8'h26), rdy(8'hEE), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 6, 1);
    add(2'b11, rdy(8'h27), rdy(8'h28), 2'b00, 0, 0, 2'b01, 0, 2'b01, 8'h20, 8'h00, 7, 0);
    add(2'b11, rdy(8'h29), rdy(8'h2A), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 6, 1);
    add(2'b00, z, z, 2'b01, 6, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 8, 0);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h21, 8'h22, 8, 0);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h23, 8'h24, 6, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h25, 8'h26, 4, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h29, 8'h2A, 2, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    // Lane 1 alone, src2 woken by the same-edge broadcast of tag 9.
    add(2'b10, rdy(8'hEF), wt2(9, 8'h30), 2'b01, 9, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b01, 8'h30, 8'h00, 1, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    // Issue and dispatch in the same cycle.
    add(2'b11, rdy(8'h40), rdy(8'h41), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b11, rdy(8'h42), rdy(8'h43), 2'b00, 0, 0, 2'b01, 0, 2'b01, 8'h40, 8'h00, 2, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b11, 8'h41, 8'h42, 3, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b01, 8'h43, 8'h00, 1, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    // Flush with 5 ready entries, a dispatch and a wakeup all pending.
    add(2'b11, rdy(8'h50), rdy(8'h51), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    add(2'b11, rdy(8'h52), rdy(8'h53), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 2, 1);
    add(2'b01, rdy(8'h54), rdy(8'hEE), 2'b00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 4, 1);
    add(2'b11, rdy(8'h55), rdy(8'h56), 2'b11, 1, 2, 2'b11, 1, 2'b00, 8'h00, 8'h00, 5, 1);
    add(2'b00, z, z, 2'b00, 0, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0, 1);

    // Reset state, observed while reset is held low.
    idle();
    iss_ready = 2'b11;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset count", count, 0);
    chk("reset dis_ready", dis_ready, 1);
    chk("reset iss_valid", iss_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d iss_valid", i), iss_valid, vecs[i].e_iv);
      chk($sformatf("v%0d count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d dis_ready", i), dis_ready, vecs[i].e_dr);
      for (int k = 0; k < 2; k++) begin
        if (vecs[i].e_iv[k]) begin
          chk($sformatf("v%0d port%0d ctrl", i, k), iss_uop[k].ctrl,
              (k == 0) ? vecs[i].e_c0 : vecs[i].e_c1);
          chk($sformatf("v%0d port%0d operands", i, k),
              (!iss_uop[k].v1 || iss_uop[k].p1) && (!iss_uop[k].v2 || iss_uop[k].p2), 1);
        end
      end
      @(negedge clk);
    end

    // Fill with 8 ready uops, then pull reset low in the middle of an issue cycle.
    for (int c = 0; c < 4; c++) begin
      idle();
      dis_valid = 2'b11;
      dis_uop[0] = rdy(8'(8'h60 + 2 * c));
      dis_uop[1] = rdy(8'(8'h61 + 2 * c));
      @(negedge clk);
    end
    idle();
    iss_ready = 2'b11;
    #1;
    chk("full count", count, 8);
    chk("full dis_ready", dis_ready, 0);
    chk("pre-reset iss_valid", iss_valid, 2'b11);
    chk("pre-reset port0 ctrl", iss_uop[0].ctrl, 8'h60);
    chk("pre-reset port1 ctrl", iss_uop[1].ctrl, 8'h61);
    #2 reset = 1'b0;
    #1;
    chk("async reset iss_valid", iss_valid, 0);
    chk("async reset count", count, 0);
    chk("async reset dis_ready", dis_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post-reset iss_valid", iss_valid, 0);
    @(negedge clk);
    #1;
    chk("post-reset count", count, 0);
    chk("post-reset idle iss_valid", iss_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
